// File: rtl/inv_test_seq_if.sv
// Signal bundle between the inverter test sequencer and its controller/target.
// The slave side is the sequencer; the master side drives start/abort and the response bit.
interface inv_test_seq_if;
   logic       start;
   logic       abort;
   logic       dut_in;
   logic       dut_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;

   modport slave (
      input  start, abort, dut_out,
      output dut_in, busy, done, pass, err_count
   );

   modport master (
      output start, abort, dut_out,
      input  dut_in, busy, done, pass, err_count
   );
endinterface

// File: rtl/inv_test_seq.sv
// Built-in test sequencer for an inverter path: drives LFSR stimulus, waits a settle
// window, samples the response and reports a mismatch count and pass/fail verdict.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; dut_in and last verdict held
// S_DRIVE  | register the next stimulus bit onto dut_in
// S_SETTLE | wait SETTLE_CYCLES cycles for the path to settle
// S_SAMPLE | compare dut_out with the expected polarity, advance LFSR
// S_DONE   | publish verdict; done pulses on the way back to idle
module inv_test_seq #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned NUM_VECTORS   = 16,
   parameter bit          INVERTING     = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   inv_test_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRIVE  = 3'd1,
      S_SETTLE = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [7:0] LFSR_SEED   = 8'hA5;
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] VEC_LAST    = 8'(NUM_VECTORS - 1);

   state_t     state_q, state_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] err_q, err_d;
   logic       dut_in_q, dut_in_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic       lfsr_fb;

   // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
   assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      dut_in_d = dut_in_q;
      done_d   = 1'b0;
      pass_d   = pass_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_DRIVE;
               err_d   = 8'd0;
               pass_d  = 1'b0;
               lfsr_d  = LFSR_SEED;
               idx_d   = 8'd0;
            end
         end
         S_DRIVE: begin
            dut_in_d = lfsr_q[0];
            cnt_d    = 8'd0;
            state_d  = S_SETTLE;
         end
         S_SETTLE: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            if ((bus.dut_out != (lfsr_q[0] ^ INVERTING)) && (err_q != 8'hFF))
               err_d = err_q + 8'd1;
            lfsr_d = {lfsr_q[6:0], lfsr_fb};
            if (idx_q == VEC_LAST) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = S_DRIVE;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            pass_d  = (err_q == 8'd0);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort freezes the datapath where it stands; only the verdict is cleared.
      if (bus.abort && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         lfsr_d   = lfsr_q;
         idx_d    = idx_q;
         cnt_d    = cnt_q;
         err_d    = err_q;
         dut_in_d = dut_in_q;
         done_d   = 1'b0;
         pass_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         lfsr_q   <= LFSR_SEED;
         idx_q    <= 8'd0;
         cnt_q    <= 8'd0;
         err_q    <= 8'd0;
         dut_in_q <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         dut_in_q <= dut_in_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   assign bus.dut_in    = dut_in_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;

endmodule

// File: tb/tb_inv_test_seq.sv
// Scoreboard bench for inv_test_seq: randomized runs against several inverter models,
// plus abort, mid-run reset, held start and error-count saturation scenarios.
module tb_inv_test_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   inv_test_seq_if bus0();
   inv_test_seq_if bus1();

   inv_test_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   inv_test_seq #(
      .SETTLE_CYCLES (1),
      .NUM_VECTORS   (256),
      .INVERTING     (1'b1)
   ) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // 0 = ideal inverter, 1 = buffer, 2 = stuck-at-0, 3 = stuck-at-1
   int model = 0;

   always_comb begin
      bus0.dut_out = ~bus0.dut_in;
      case (model)
         1:       bus0.dut_out = bus0.dut_in;
         2:       bus0.dut_out = 1'b0;
         3:       bus0.dut_out = 1'b1;
         default: bus0.dut_out = ~bus0.dut_in;
      endcase
   end

   assign bus1.dut_out = bus1.dut_in;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int err;
      int pass;
      int lat;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected mismatch count for one 16-vector run, from the stimulus sequence itself.
   function automatic int ref_err(input int m, input int nv);
      logic [7:0] l = 8'hA5;
      int         n = 0;
      bit         s, want, got;
      for (int i = 0; i < nv; i++) begin
         s    = l[0];
         want = ~s;
         case (m)
            0:       got = ~s;
            1:       got = s;
            2:       got = 1'b0;
            default: got = 1'b1;
         endcase
         if (got != want) n++;
         l = {l[6:0], ^(l & 8'hB8)};
      end
      return (n > 255) ? 255 : n;
   endfunction

   int   t_start   = 0;
   logic busy_prev = 1'b0;
   int   done_seen = 0;
   exp_t e;

   always @(negedge clk) begin
      if (bus0.busy && !busy_prev) t_start = cyc;
      busy_prev = bus0.busy;
      if (bus0.done) begin
         done_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending run at cycle %0d", cyc);
         end else begin
            e = sb.pop_front();
            check("err_count", int'(bus0.err_count), e.err);
            check("pass", int'(bus0.pass), e.pass);
            check("done_latency", cyc - t_start, e.lat);
         end
      end
   end

   task automatic wait_busy(input logic lvl, input int max, input string name);
      int n = 0;
      while (bus0.busy !== lvl && n < max) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus0.busy !== lvl) begin
         errors++;
         $display("FAIL %s: got busy=%0b expected %0b within %0d cycles", name, bus0.busy, lvl, max);
      end
   endtask

   task automatic run(input int m, input bit hold, input bit abort_too);
      int x;
      model = m;
      x = ref_err(m, 16);
      sb.push_back('{x, (x == 0) ? 1 : 0, 65});
      bus0.start = 1'b1;
      bus0.abort = abort_too;
      @(negedge clk);
      bus0.abort = 1'b0;
      if (!hold) bus0.start = 1'b0;
      wait_busy(1'b0, 200, "run_end");
      bus0.start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0, t0, n;
      bus0.start = 1'b0;
      bus0.abort = 1'b0;
      bus1.start = 1'b0;
      bus1.abort = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", int'(bus0.busy), 0);
      check("rst_done", int'(bus0.done), 0);
      check("rst_pass", int'(bus0.pass), 0);
      check("rst_err", int'(bus0.err_count), 0);
      check("rst_dut_in", int'(bus0.dut_in), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run(0, 1'b0, 1'b0);
      run(1, 1'b0, 1'b0);
      run(2, 1'b0, 1'b0);
      run(3, 1'b0, 1'b0);
      run(1, 1'b0, 1'b1);

      repeat (8) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Abort during vector 5 with a buffer model: five mismatches already counted.
      model = 1;
      d0 = done_seen;
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      check("abort_busy_before", int'(bus0.busy), 1);
      repeat (21) @(negedge clk);
      bus0.abort = 1'b1;
      @(negedge clk);
      bus0.abort = 1'b0;
      check("abort_busy", int'(bus0.busy), 0);
      check("abort_err_hold", int'(bus0.err_count), 5);
      check("abort_pass", int'(bus0.pass), 0);
      repeat (10) @(negedge clk);
      check("abort_no_done", done_seen - d0, 0);
      check("abort_stays_idle", int'(bus0.busy), 0);
      run(0, 1'b0, 1'b0);

      // Asynchronous reset while in SETTLE of vector 1.
      model = 1;
      d0 = done_seen;
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      repeat (6) @(negedge clk);
      check("pre_rst_err", int'(bus0.err_count), 1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", int'(bus0.busy), 0);
      check("arst_err", int'(bus0.err_count), 0);
      check("arst_dut_in", int'(bus0.dut_in), 0);
      check("arst_pass", int'(bus0.pass), 0);
      check("arst_done", int'(bus0.done), 0);
      #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_idle", int'(bus0.busy), 0);
      check("post_rst_no_done", done_seen - d0, 0);

      // Start held high for the whole run yields exactly one run.
      d0 = done_seen;
      run(0, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      check("held_start_runs", done_seen - d0, 1);
      check("held_start_idle", int'(bus0.busy), 0);

      // Saturation instance: 256 vectors, buffer response, one settle cycle.
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      t0 = cyc;
      n  = 0;
      while (!bus1.done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("sat_done_seen", int'(bus1.done), 1);
      check("sat_err", int'(bus1.err_count), 255);
      check("sat_pass", int'(bus1.pass), 0);
      check("sat_latency", cyc - t0, 769);

      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inv_test_seq.md
INV_TEST_SEQ -- requirements
Module: inv_test_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of wait cycles between driving the stimulus and sampling the inverter output; legal range 1..255.
REQ-002 Parameter NUM_VECTORS, default 16, number of test vectors per run; legal range 1..256.
REQ-003 Parameter INVERTING, default 1, expected path polarity: 1 means dut_out = ~dut_in, 0 means dut_out = dut_in (even-length chain).
REQ-004 clk  input  1  single clock, rising-edge active; one clock domain only.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  level-sampled request to begin a run; honoured only in IDLE.
REQ-007 abort  input  1  synchronous abort of a run in progress.
REQ-008 dut_in  output  1  stimulus bit driven to the inverter under test.
REQ-009 dut_out  input  1  response bit returned from the inverter under test.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse at run completion.
REQ-012 pass  output  1  run verdict; valid from done until the next accepted start.
REQ-013 err_count  output  8  mismatch count of the current or last run.

Function
REQ-014 States: IDLE, DRIVE, SETTLE, SAMPLE, DONE; every state is registered.
REQ-015 Stimulus: 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, loaded on accepted start; stimulus bit = lfsr[0].
REQ-016 IDLE: start=1 -> DRIVE; same edge clears err_count and pass, loads the seed and zeroes the vector index.
REQ-017 DRIVE: dut_in registered <= lfsr[0]; settle counter <= 0; next state SETTLE.
REQ-018 SETTLE: counter increments each cycle; after exactly SETTLE_CYCLES cycles in SETTLE -> SAMPLE.
REQ-019 SAMPLE: expected = lfsr[0] XOR INVERTING; dut_out != expected -> err_count increments, saturating at 8'hFF with no wrap.
REQ-020 SAMPLE: the LFSR advances one step; if vector index == NUM_VECTORS-1 -> DONE, else index+1 and -> DRIVE.
REQ-021 Per-vector latency is SETTLE_CYCLES+2 cycles; done asserts exactly 1 + NUM_VECTORS*(SETTLE_CYCLES+2) rising edges after the edge that accepts start.
REQ-022 DONE: done=1 for this single cycle; pass <= (err_count==0), counting a mismatch from the final SAMPLE; next state IDLE.
REQ-023 start while busy=1 is ignored; no queuing or restart.
REQ-024 abort=1 in any non-IDLE state -> IDLE on the next edge; done is not pulsed, pass=0, err_count holds its value.
REQ-025 abort and start both high in IDLE: start is honoured and abort is ignored.
REQ-026 dut_in holds its last driven value in IDLE, SETTLE, SAMPLE and DONE.
REQ-027 If the inverter output is still settling when sampled, the result is counted as it is sampled; the block never retries a vector.

Reset
REQ-028 rst_n=0 forces IDLE immediately, with dut_in=0, busy=0, done=0, pass=0, err_count=0, LFSR=8'hA5, vector index and settle counter=0.
REQ-029 Reset asserted mid-run discards the run with no done pulse; after release the block waits in IDLE for a fresh start.

Verification
REQ-030 Bench provides an ideal inverter model; start pulse with defaults -> done exactly 65 edges later, pass=1, err_count=0.
REQ-031 Model replaced by a buffer (INVERTING=1) -> after 16 vectors, done asserts with pass=0 and err_count=16.
REQ-032 Stuck-at-0 model -> err_count equals the number of zero stimulus bits in the first 16 LFSR outputs from seed A5; pass=0.
REQ-033 abort at vector 5 -> busy falls on the next edge, done never pulses, pass=0; a following start runs clean with err_count=0.
REQ-034 rst_n pulsed low in SETTLE -> all outputs take their reset values asynchronously; start held high throughout busy -> exactly one run occurs.
REQ-035 NUM_VECTORS=256 with a buffer model -> err_count saturates at 255 and does not wrap.
